// File: rtl/gd_iter_engine.sv
// Fixed-point gradient-descent iteration engine: requests a gradient for x, applies x -= lr*grad
// with saturation, and hands (x_next, x) to an external convergence checker until it converges or hits MAX_ITER.
module gd_iter_engine #(
  parameter logic [15:0] MAX_ITER = 16'd1024,
  parameter int unsigned LR_FRAC  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x0,
  input  logic [31:0] lr,
  output logic        grad_req_valid,
  input  logic        grad_req_ready,
  output logic [31:0] grad_x,
  input  logic        grad_rsp_valid,
  input  logic [31:0] grad_rsp_data,
  output logic        pair_valid,
  input  logic        pair_ready,
  output logic [31:0] pair_a,
  output logic [31:0] pair_b,
  input  logic        converged,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_final,
  output logic [15:0] iter_count,
  output logic [1:0]  status
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_RSP, S_UPDATE, S_EMIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] lr_q, lr_d;
  logic [31:0] grad_q, grad_d;
  logic [31:0] xn_q, xn_d;
  logic [31:0] xf_q, xf_d;
  logic [15:0] iter_q, iter_d;
  logic [1:0]  status_q, status_d;
  logic        done_q, done_d;

  logic signed [63:0] prod, step_wide;
  logic        [31:0] step_sat;
  logic signed [32:0] diff;
  logic        [31:0] x_next;
  logic        [15:0] iter_inc;

  // Update datapath: widen to 64 bits, rescale, then clamp twice (step, then x - step).
  always_comb begin
    prod      = $signed({{32{grad_q[31]}}, grad_q}) * $signed({{32{lr_q[31]}}, lr_q});
    step_wide = prod >>> LR_FRAC;
    if (step_wide > 64'sh0000_0000_7FFF_FFFF)
      step_sat = 32'h7FFF_FFFF;
    else if (step_wide < 64'shFFFF_FFFF_8000_0000)
      step_sat = 32'h8000_0000;
    else
      step_sat = step_wide[31:0];
    diff = $signed({x_q[31], x_q}) - $signed({step_sat[31], step_sat});
    if (diff[32] != diff[31])
      x_next = diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      x_next = diff[31:0];
  end

  assign iter_inc = iter_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    lr_d     = lr_q;
    grad_d   = grad_q;
    xn_d     = xn_q;
    xf_d     = xf_q;
    iter_d   = iter_q;
    status_d = status_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d      = x0;
          lr_d     = lr;
          iter_d   = '0;
          status_d = 2'b00;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (grad_req_ready) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (grad_rsp_valid) begin
          grad_d  = grad_rsp_data;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        xn_d    = x_next;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (pair_ready) begin
          iter_d = iter_inc;
          x_d    = xn_q;
          xf_d   = xn_q;
          // Convergence wins over the iteration limit on the same handshake.
          if (converged) begin
            status_d = 2'b01;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else if (iter_inc == MAX_ITER) begin
            status_d = 2'b10;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else begin
            state_d  = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      lr_q     <= '0;
      grad_q   <= '0;
      xn_q     <= '0;
      xf_q     <= '0;
      iter_q   <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      lr_q     <= lr_d;
      grad_q   <= grad_d;
      xn_q     <= xn_d;
      xf_q     <= xf_d;
      iter_q   <= iter_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign grad_req_valid = (state_q == S_REQ);
  assign pair_valid     = (state_q == S_EMIT);
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = done_q;
  assign grad_x         = x_q;
  assign pair_a         = xn_q;
  assign pair_b         = x_q;
  assign x_final        = xf_q;
  assign iter_count     = iter_q;
  assign status         = status_q;

endmodule

// File: tb/tb_gd_iter_engine.sv
// Directed bench for gd_iter_engine (MAX_ITER=4): update arithmetic, saturation, convergence,
// iteration limit, EMIT back-pressure and mid-run reset.
module tb_gd_iter_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x0, lr;
  logic        grad_req_valid, grad_req_ready;
  logic [31:0] grad_x;
  logic        grad_rsp_valid;
  logic [31:0] grad_rsp_data;
  logic        pair_valid, pair_ready;
  logic [31:0] pair_a, pair_b;
  logic        converged;
  logic        busy, done;
  logic [31:0] x_final;
  logic [15:0] iter_count;
  logic [1:0]  status;

  logic        conv_force, conv_model_en;
  logic signed [31:0] diff_ab, abs_ab;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Checker model: converged when |pair_a - pair_b| < 0x40.
  assign diff_ab   = $signed(pair_a) - $signed(pair_b);
  assign abs_ab    = (diff_ab < 0) ? -diff_ab : diff_ab;
  assign converged = conv_force | (conv_model_en & (abs_ab < 32'sh40));

  gd_iter_engine #(
    .MAX_ITER (16'd4),
    .LR_FRAC  (8)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .x0             (x0),
    .lr             (lr),
    .grad_req_valid (grad_req_valid),
    .grad_req_ready (grad_req_ready),
    .grad_x         (grad_x),
    .grad_rsp_valid (grad_rsp_valid),
    .grad_rsp_data  (grad_rsp_data),
    .pair_valid     (pair_valid),
    .pair_ready     (pair_ready),
    .pair_a         (pair_a),
    .pair_b         (pair_b),
    .converged      (converged),
    .busy           (busy),
    .done           (done),
    .x_final        (x_final),
    .iter_count     (iter_count),
    .status         (status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] xv, input logic [31:0] lv);
    start = 1'b1; x0 = xv; lr = lv;
    tick();
    start = 1'b0;
  endtask

  // Drive one gradient transaction; returns with the engine in EMIT.
  task automatic serve(input logic [31:0] g);
    int n = 0;
    while (!grad_req_valid && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(grad_req_valid), 32'd1);
    tick();
    grad_rsp_valid = 1'b1;
    grad_rsp_data  = g;
    tick();
    grad_rsp_valid = 1'b0;
    check("pv_in_update", 32'(pair_valid), 32'd0);
    tick();
    check("pv_in_emit", 32'(pair_valid), 32'd1);
  endtask

  task automatic run_single(input string tag, input logic [31:0] xv, input logic [31:0] lv,
                            input logic [31:0] g, input logic [31:0] exp_a);
    conv_force = 1'b1;
    pair_ready = 1'b1;
    do_start(xv, lv);
    serve(g);
    check({tag, "_pair_a"}, pair_a, exp_a);
    check({tag, "_pair_b"}, pair_b, xv);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_status"}, 32'(status), 32'd1);
    check({tag, "_x_final"}, x_final, exp_a);
  endtask

  initial begin
    int gi;
    int xf_dist;
    rst = 1'b1; start = 1'b0; x0 = '0; lr = '0;
    grad_req_ready = 1'b1; grad_rsp_valid = 1'b0; grad_rsp_data = '0;
    pair_ready = 1'b0; conv_force = 1'b0; conv_model_en = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(grad_req_valid), 32'd0);
    check("rst_pv", 32'(pair_valid), 32'd0);
    check("rst_grad_x", grad_x, 32'd0);
    check("rst_pair_a", pair_a, 32'd0);
    check("rst_x_final", x_final, 32'd0);
    check("rst_iter", 32'(iter_count), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    rst = 1'b0;
    tick();

    // Convergence run on f=(x-3)^2; first step also exercises EMIT back-pressure.
    conv_model_en = 1'b1;
    do_start(32'h0, 32'h40);
    check("run_busy", 32'(busy), 32'd1);
    check("req_grad_x", grad_x, 32'h0);
    serve(32'hFFFF_FA00);
    check("first_pair_a", pair_a, 32'h0000_0180);
    check("first_pair_b", pair_b, 32'h0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1); x0 = 32'h1234_5678;
      grad_rsp_valid = (i == 2); grad_rsp_data = 32'h0000_7000;
      tick();
      check("hold_pv", 32'(pair_valid), 32'd1);
      check("hold_pair_a", pair_a, 32'h0000_0180);
      check("hold_pair_b", pair_b, 32'h0);
      check("hold_iter", 32'(iter_count), 32'd0);
    end
    start = 1'b0; grad_rsp_valid = 1'b0;
    pair_ready = 1'b1;
    tick();
    check("acc_iter", 32'(iter_count), 32'd1);
    check("acc_grad_x", grad_x, 32'h0000_0180);
    check("acc_req", 32'(grad_req_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      gi = 2 * ($signed(grad_x) - 32'sh300);
      serve(32'(gi));
      tick();
    end
    check("conv_done", 32'(done), 32'd1);
    check("conv_status", 32'(status), 32'd1);
    check("conv_iter", 32'(iter_count), 32'd4);
    check("conv_x_final", x_final, 32'h0000_02D0);
    check("conv_busy", 32'(busy), 32'd0);
    xf_dist = $signed(x_final) - 32'sh300;
    if (xf_dist < 0) xf_dist = -xf_dist;
    check("conv_near_3", 32'(xf_dist <= 32'sh80), 32'd1);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("done_hold_status", 32'(status), 32'd1);
    check("done_hold_xf", x_final, 32'h0000_02D0);

    // Iteration limit with the checker never agreeing.
    conv_model_en = 1'b0;
    do_start(32'h0, 32'h40);
    check("restart_status", 32'(status), 32'd0);
    check("restart_iter", 32'(iter_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      serve(32'hFFFF_FF00);
      tick();
      check("lim_iter", 32'(iter_count), 32'(i + 1));
    end
    check("lim_done", 32'(done), 32'd1);
    check("lim_status", 32'(status), 32'd2);
    check("lim_x_final", x_final, 32'h0000_0100);

    run_single("sat_pos", 32'h7FFF_FF00, 32'h100, 32'h8000_0000, 32'h7FFF_FFFF);
    run_single("sat_neg", 32'h8000_0100, 32'h100, 32'h7FFF_FFFF, 32'h8000_0000);
    run_single("sat_step", 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0001);

    // Asynchronous reset in WAIT_RSP.
    conv_force = 1'b0;
    do_start(32'h500, 32'h40);
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_req", 32'(grad_req_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req", 32'(grad_req_valid), 32'd0);
    check("arst_pv", 32'(pair_valid), 32'd0);
    check("arst_grad_x", grad_x, 32'd0);
    check("arst_pair_a", pair_a, 32'd0);
    check("arst_x_final", x_final, 32'd0);
    check("arst_iter", 32'(iter_count), 32'd0);
    check("arst_status", 32'(status), 32'd0);
    rst = 1'b0;
    grad_rsp_valid = 1'b1; grad_rsp_data = 32'h0000_0100;
    tick();
    grad_rsp_valid = 1'b0;
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_no_pv", 32'(pair_valid), 32'd0);
    run_single("post_rst", 32'h0, 32'h40, 32'hFFFF_FA00, 32'h0000_0180);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
